mlp_feature_loader: RTL and testbench
=====================================

MLP_FEATURE_LOADER -- requirements
Module: mlp_feature_loader

Interface
REQ-001 Parameter NFEAT, default 6: number of features per frame.
REQ-002 Parameter FBITS, default 4: width of each feature sample in bits.
REQ-003 Parameter CBITS, default 2: width of the class index.
REQ-004 Parameter SETTLE, default 4, legal range 1..255: cycles allowed for the combinational classifier to settle.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 s_valid  input  1  sensor/ADC sample valid.
REQ-008 s_ready  output  1  loader accepts a sample this cycle.
REQ-009 s_data  input  FBITS  unsigned feature sample.
REQ-010 s_last  input  1  marks the final sample of a frame.
REQ-011 mlp_inp  output  NFEAT*FBITS  packed feature vector driven to the classifier; feature k occupies bits [k*FBITS+FBITS-1 : k*FBITS].
REQ-012 mlp_out  input  CBITS  class index returned by the classifier.
REQ-013 m_valid  output  1  classification result valid.
REQ-014 m_ready  input  1  downstream accepts the result.
REQ-015 m_class  output  CBITS  registered class index.
REQ-016 err_cnt  output  8  count of frame errors, saturating.

Function
REQ-017 The FSM SHALL have exactly three states: COLLECT, SETTLE and HOLD.
REQ-018 s_ready SHALL be 1 only in COLLECT and only while rst_n=1.
REQ-019 A sample SHALL be accepted on a rising edge where s_valid=1 and s_ready=1; it SHALL be written to slot idx of mlp_inp, and idx SHALL then increment.
REQ-020 The first sample of a frame SHALL be feature 0 (mlp_inp[FBITS-1:0]), in arrival order.
REQ-021 mlp_inp SHALL change only on an accepted sample; it SHALL hold stable throughout SETTLE and HOLD.
REQ-022 When the accepted sample has idx=NFEAT-1 and s_last=1, the FSM SHALL enter SETTLE and load the settle counter with SETTLE-1.
REQ-023 Frame error: on an accepted sample where s_last=1 and idx≠NFEAT-1, or where idx=NFEAT-1 and s_last=0:
- idx SHALL return to 0;
- the FSM SHALL stay in COLLECT;
- err_cnt SHALL increment, saturating at 255;
- the sample SHALL still be written to mlp_inp, and the frame SHALL be discarded (no result is produced).
REQ-024 In SETTLE, the counter SHALL decrement on each edge while it is nonzero; on the edge where it equals 0, mlp_out SHALL be registered into m_class and the FSM SHALL enter HOLD.
REQ-025 Latency: m_valid SHALL first be high exactly SETTLE rising edges after the edge that accepted the last sample.
REQ-026 In HOLD, m_valid SHALL be 1 and m_class SHALL be stable until the edge where m_ready=1; on that edge the FSM SHALL enter COLLECT with idx=0 and m_valid SHALL go to 0.
REQ-027 m_valid SHALL be 0 in COLLECT and SETTLE.
REQ-028 In SETTLE and HOLD, s_valid, s_data and s_last SHALL be ignored.
REQ-029 If m_ready is already 1 when HOLD is entered, m_valid SHALL be high for exactly one cycle.
REQ-030 idx SHALL never exceed NFEAT-1, and there SHALL be no wrap without a frame end or a frame error.

Reset
REQ-031 While rst_n=0 at a rising edge, the block SHALL set:
- FSM to COLLECT, idx to 0;
- mlp_inp to 0, m_class to 0, m_valid to 0;
- err_cnt to 0, settle counter to 0.
REQ-032 Reset asserted mid-frame, in SETTLE or in HOLD SHALL abandon the frame or result with no output handshake.
REQ-033 The first sample after reset release SHALL be treated as feature 0.

Verification
REQ-034 Nominal frame: samples 1,2,3,4,5,6 with s_last on the 6th, m_ready=1 -> mlp_inp=24'h654321; m_valid high for one cycle, 4 edges after the accept; m_class equals mlp_out sampled on that capture edge.
REQ-035 Backpressure: m_ready=0 for 10 cycles in HOLD -> m_valid and m_class stable; s_ready=0 throughout; a new frame is accepted only after the m_ready handshake.
REQ-036 Early s_last on the 3rd sample -> err_cnt 0→1, no m_valid; a following correct 6-sample frame is classified normally.
REQ-037 Missing s_last on the 6th sample -> err_cnt increments, idx=0; 256 consecutive bad frames -> err_cnt=255 (saturated).
REQ-038 Reset during SETTLE (counter=2) -> next cycle: m_valid=0, mlp_inp=0, s_ready=1 once rst_n=1; no result emitted.
REQ-039 s_valid toggled randomly with gaps during COLLECT -> only handshaken samples are stored; SETTLE=1 build -> m_valid high 1 edge after the last accept.

Source files
------------

// File: rtl/mlp_feature_loader.sv
// Collects NFEAT sensor samples into a packed feature vector, waits SETTLE cycles for a
// combinational classifier, then holds the registered class index until it is accepted.
module mlp_feature_loader #(
  parameter int unsigned NFEAT  = 6,
  parameter int unsigned FBITS  = 4,
  parameter int unsigned CBITS  = 2,
  parameter int unsigned SETTLE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [FBITS-1:0]       s_data,
  input  logic                   s_last,
  output logic [NFEAT*FBITS-1:0] mlp_inp,
  input  logic [CBITS-1:0]       mlp_out,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [CBITS-1:0]       m_class,
  output logic [7:0]             err_cnt
);

  localparam int unsigned     IdxW       = (NFEAT > 1) ? $clog2(NFEAT) : 1;
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(NFEAT - 1);
  localparam logic [7:0]      SettleInit = 8'(SETTLE - 1);

  typedef enum logic [1:0] {StCollect, StSettle, StHold} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [NFEAT*FBITS-1:0] inp_q, inp_d;
  logic [CBITS-1:0]       class_q, class_d;
  logic [7:0]             err_q, err_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   at_last;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    inp_d   = inp_q;
    class_d = class_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    at_last = (idx_q == LastIdx);
    unique case (state_q)
      StCollect: begin
        if (s_valid) begin
          for (int unsigned k = 0; k < NFEAT; k++) begin
            if (idx_q == IdxW'(k)) inp_d[k*FBITS +: FBITS] = s_data;
          end
          if (s_last && at_last) begin
            state_d = StSettle;
            cnt_d   = SettleInit;
            idx_d   = '0;
          end else if (s_last || at_last) begin
            // Misframed: keep the written sample but drop the frame.
            idx_d = '0;
            if (err_q != 8'hff) err_d = err_q + 8'd1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StSettle: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          class_d = mlp_out;
          state_d = StHold;
        end
      end
      StHold: begin
        if (m_ready) begin
          state_d = StCollect;
          idx_d   = '0;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StCollect;
      idx_q   <= '0;
      inp_q   <= '0;
      class_q <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      inp_q   <= inp_d;
      class_q <= class_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s_ready = rst_n && (state_q == StCollect);
  assign m_valid = (state_q == StHold);
  assign mlp_inp = inp_q;
  assign m_class = class_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_mlp_feature_loader.sv
// Bench for mlp_feature_loader: two instances (SETTLE=4 and SETTLE=1) share one stimulus
// stream and are each checked every cycle against a frame-level model.
module tb_mlp_feature_loader;

  localparam int NF = 6;
  localparam int FB = 4;
  localparam int CB = 2;
  localparam int W  = NF * FB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          m_ready = 1'b0;
  logic [FB-1:0] s_data = '0;
  logic [CB-1:0] mlp_out = '0;

  logic          s_ready [2];
  logic          m_valid [2];
  logic [W-1:0]  mlp_inp [2];
  logic [CB-1:0] m_class [2];
  logic [7:0]    err_cnt [2];

  int nvec = 0;
  int nerr = 0;
  bit chk_on = 1'b0;

  // Model state: samples taken in this frame, edges left until the result, result pending.
  int            fill [2];
  int            pend [2];
  bit            hold [2];
  int            errs [2];
  logic [W-1:0]  e_inp [2];
  logic [CB-1:0] e_cls [2];

  mlp_feature_loader #(.NFEAT(NF), .FBITS(FB), .CBITS(CB), .SETTLE(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[0]), .s_data(s_data),
    .s_last(s_last), .mlp_inp(mlp_inp[0]), .mlp_out(mlp_out), .m_valid(m_valid[0]),
    .m_ready(m_ready), .m_class(m_class[0]), .err_cnt(err_cnt[0])
  );

  mlp_feature_loader #(.NFEAT(NF), .FBITS(FB), .CBITS(CB), .SETTLE(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[1]), .s_data(s_data),
    .s_last(s_last), .mlp_inp(mlp_inp[1]), .mlp_out(mlp_out), .m_valid(m_valid[1]),
    .m_ready(m_ready), .m_class(m_class[1]), .err_cnt(err_cnt[1])
  );

  always #5 clk = ~clk;

  // Stand-in classifier: a fresh random class every cycle, so capture timing is visible.
  always begin
    @(posedge clk);
    #2 mlp_out = CB'($urandom);
  end

  function automatic int settle_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        fill[k]  <= 0;
        pend[k]  <= 0;
        hold[k]  <= 1'b0;
        errs[k]  <= 0;
        e_inp[k] <= '0;
        e_cls[k] <= '0;
      end else if (hold[k]) begin
        if (m_ready) hold[k] <= 1'b0;
      end else if (pend[k] > 0) begin
        pend[k] <= pend[k] - 1;
        if (pend[k] == 1) begin
          hold[k]  <= 1'b1;
          e_cls[k] <= mlp_out;
        end
      end else if (s_valid) begin
        e_inp[k][fill[k]*FB +: FB] <= s_data;
        if (s_last && fill[k] == NF - 1) begin
          pend[k] <= settle_of(k);
          fill[k] <= 0;
        end else if (s_last || fill[k] == NF - 1) begin
          fill[k] <= 0;
          if (errs[k] < 255) errs[k] <= errs[k] + 1;
        end else begin
          fill[k] <= fill[k] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("s_ready%0d", k), 64'(s_ready[k]),
            64'(rst_n && !hold[k] && pend[k] == 0));
        chk($sformatf("m_valid%0d", k), 64'(m_valid[k]), 64'(hold[k]));
        chk($sformatf("mlp_inp%0d", k), 64'(mlp_inp[k]), 64'(e_inp[k]));
        chk($sformatf("m_class%0d", k), 64'(m_class[k]), 64'(e_cls[k]));
        chk($sformatf("err_cnt%0d", k), 64'(err_cnt[k]), 64'(errs[k]));
      end
    end
  end

  task automatic send(input int d, input bit last);
    s_valid = 1'b1;
    s_data  = FB'(d);
    s_last  = last;
    @(posedge clk);
    #2;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic frame(input int base);
    for (int i = 1; i <= NF; i++) send(base + i, i == NF);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!m_valid[0] && n < 30) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!m_valid[0]) chk(name, 64'(m_valid[0]), 64'd1);
  endtask

  initial begin
    int n0, n1, hi0;
    logic [CB-1:0] held;

    repeat (3) @(posedge clk);
    #2;
    chk_on = 1'b1;
    chk("rst_inp", 64'(mlp_inp[0]), 64'd0);
    chk("rst_err", 64'(err_cnt[0]), 64'd0);
    chk("rst_ready", 64'(s_ready[0]), 64'd0);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #2;

    // Nominal frame and latency for both SETTLE builds.
    frame(0);
    chk("nom_inp", 64'(mlp_inp[0]), 64'h654321);
    chk("nom_inp_s1", 64'(mlp_inp[1]), 64'h654321);
    n0 = -1; n1 = -1; hi0 = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #2;
      if (m_valid[0]) hi0++;
      if (m_valid[0] && n0 < 0) n0 = c;
      if (m_valid[1] && n1 < 0) n1 = c;
    end
    chk("lat_settle4", 64'(n0), 64'd4);
    chk("lat_settle1", 64'(n1), 64'd1);
    chk("pulse_len", 64'(hi0), 64'd1);

    // Backpressure in HOLD with junk samples presented.
    m_ready = 1'b0;
    frame(8);
    wait_valid("bp_timeout");
    held = m_class[0];
    for (int c = 0; c < 10; c++) begin
      s_valid = 1'b1;
      s_data  = FB'($urandom);
      s_last  = 1'(c % 2);
      @(posedge clk);
      #2;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("bp_valid", 64'(m_valid[0]), 64'd1);
    chk("bp_class", 64'(m_class[0]), 64'(held));
    chk("bp_inp", 64'(mlp_inp[0]), 64'hEDCBA9);
    m_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("bp_release", 64'(m_valid[0]), 64'd0);

    // Early s_last, then a good frame.
    send(1, 1'b0); send(2, 1'b0); send(3, 1'b1);
    chk("early_err", 64'(err_cnt[0]), 64'd1);
    frame(3);
    wait_valid("early_timeout");
    repeat (2) @(posedge clk);
    #2;
    chk("early_err_kept", 64'(err_cnt[0]), 64'd1);

    // Missing s_last, then saturation.
    for (int i = 1; i <= NF; i++) send(i, 1'b0);
    chk("miss_err", 64'(err_cnt[0]), 64'd2);
    for (int i = 0; i < 256; i++) send(i, 1'b1);
    chk("sat_err", 64'(err_cnt[0]), 64'd255);
    chk("sat_err_s1", 64'(err_cnt[1]), 64'd255);

    // Reset while the settle counter is at 2.
    m_ready = 1'b0;
    frame(5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_settle_valid", 64'(m_valid[0]), 64'd0);
    chk("rst_settle_inp", 64'(mlp_inp[0]), 64'd0);
    chk("rst_settle_err", 64'(err_cnt[0]), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_settle_ready", 64'(s_ready[0]), 64'd1);
    @(posedge clk);
    #2;

    // Random traffic with gaps, backpressure and rare resets.
    repeat (3000) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = FB'($urandom);
      s_last  = (fill[0] == NF - 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 24) == 0);
      m_ready = ($urandom_range(0, 2) != 0);
      rst_n   = ($urandom_range(0, 999) != 0);
      @(posedge clk);
      #2;
    end
    s_valid = 1'b0;
    rst_n   = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
